// File: rtl/reg_bank_arbiter_pkg.sv
// rtl/reg_bank_arbiter_pkg.sv - shared types and constants for the arbitrated register bank
package reg_bank_arbiter_pkg;

  localparam int DEF_NUM_REGS     = 32;
  localparam int DEF_REG_WIDTH    = 8;
  localparam int DEF_ADDR_WIDTH   = 5;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STARVE_W         = 4;
  localparam int CNT_W            = 8;

  typedef enum logic {
    PRIO_A  = 1'b0,
    FORCE_B = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_REG_WIDTH-1:0]  wdata;
  } req_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// rtl/reg_bank_arbiter_if.sv - one requester port of the register bank
interface reg_bank_arbiter_if
  import reg_bank_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_WIDTH  = DEF_REG_WIDTH
) ();

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REG_WIDTH-1:0]  wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [REG_WIDTH-1:0]  rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/reg_bank_arbiter_arb_fsm_2port.sv
// rtl/reg_bank_arbiter_arb_fsm_2port.sv - A-priority arbiter with starvation override for port B
module arb_fsm_2port
  import reg_bank_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena_i,
  input  logic a_req_i,
  input  logic b_req_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                a_gnt, b_gnt;
  logic                en;

  // Grants are withheld while reset is asserted so no access starts mid-reset.
  assign en = ena_i & rstb;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    if (en) begin
      unique case (state_q)
        PRIO_A: begin
          a_gnt = a_req_i;
          b_gnt = b_req_i & ~a_req_i;
        end
        FORCE_B: begin
          b_gnt = b_req_i;
          a_gnt = a_req_i & ~b_req_i;
        end
      endcase
      starve_d = (b_req_i && !b_gnt) ? starve_q + 1'b1 : '0;
      // In FORCE_B the counter always clears, so this also handles the return to PRIO_A.
      state_d  = (starve_d == LIMIT) ? FORCE_B : PRIO_A;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q  <= PRIO_A;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign a_gnt_o = a_gnt;
  assign b_gnt_o = b_gnt;

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - shared configuration register bank serving two arbitrated ports
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int REG_WIDTH    = DEF_REG_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          ena,
  reg_bank_arbiter_if.slave             port_a,
  reg_bank_arbiter_if.slave             port_b,
  output logic [NUM_REGS*REG_WIDTH-1:0] config_regs,
  output logic [CNT_W-1:0]              contention_cnt
);

  logic [NUM_REGS*REG_WIDTH-1:0] regs_q, regs_d;
  logic [CNT_W-1:0]              cont_q, cont_d;
  logic                          a_gnt, b_gnt;
  logic                          a_rvalid_q, b_rvalid_q;
  logic [REG_WIDTH-1:0]          a_rdata_q, a_rdata_d;
  logic [REG_WIDTH-1:0]          b_rdata_q, b_rdata_d;
  logic                          wr_en;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [REG_WIDTH-1:0]          wr_data;

  arb_fsm_2port #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk    (clk),
    .rstb   (rstb),
    .ena_i  (ena),
    .a_req_i(port_a.req),
    .b_req_i(port_b.req),
    .a_gnt_o(a_gnt),
    .b_gnt_o(b_gnt)
  );

  function automatic logic [REG_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] addr);
    rd_word = '0;
    if (int'(addr) < NUM_REGS)
      rd_word = regs_q[int'(addr)*REG_WIDTH +: REG_WIDTH];
  endfunction

  // Grants are mutually exclusive, so a single write port suffices.
  assign wr_en   = (a_gnt & port_a.we) | (b_gnt & port_b.we);
  assign wr_addr = a_gnt ? port_a.addr  : port_b.addr;
  assign wr_data = a_gnt ? port_a.wdata : port_b.wdata;

  always_comb begin
    regs_d = regs_q;
    if (wr_en && int'(wr_addr) < NUM_REGS)
      regs_d[int'(wr_addr)*REG_WIDTH +: REG_WIDTH] = wr_data;
  end

  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_gnt && !port_a.we)
      a_rdata_d = rd_word(port_a.addr);
    if (b_gnt && !port_b.we)
      b_rdata_d = rd_word(port_b.addr);
  end

  always_comb begin
    cont_d = cont_q;
    if (ena && port_a.req && port_b.req)
      cont_d = sat_inc(cont_q);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      regs_q     <= '0;
      cont_q     <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      cont_q     <= cont_d;
      a_rvalid_q <= a_gnt & ~port_a.we;
      b_rvalid_q <= b_gnt & ~port_b.we;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // A reset arriving while read data is in flight must not present it as valid.
  assign port_a.gnt    = a_gnt;
  assign port_a.rvalid = a_rvalid_q & rstb;
  assign port_a.rdata  = a_rdata_q;
  assign port_b.gnt    = b_gnt;
  assign port_b.rvalid = b_rvalid_q & rstb;
  assign port_b.rdata  = b_rdata_q;

  assign config_regs    = regs_q;
  assign contention_cnt = cont_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;

  localparam int NR = 20;
  localparam int RW = 8;
  localparam int AW = 5;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rstb;
  logic ena;
  always #5 clk = ~clk;

  reg_bank_arbiter_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) a_if ();
  reg_bank_arbiter_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) b_if ();

  logic [NR*RW-1:0] cfg;
  logic [7:0]       ccnt;

  reg_bank_arbiter #(
    .NUM_REGS(NR), .REG_WIDTH(RW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)
  ) dut (
    .clk           (clk),
    .rstb          (rstb),
    .ena           (ena),
    .port_a        (a_if),
    .port_b        (b_if),
    .config_regs   (cfg),
    .contention_cnt(ccnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [NR*RW-1:0] act, input logic [NR*RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: bank contents, B's consecutive-denial count, read results.
  logic [7:0] m_regs [NR];
  int         m_starve;
  int         m_cont;
  bit         m_rva, m_rvb;
  logic [7:0] m_rda, m_rdb;
  bit         m_valid = 1'b0;
  int         both_cnt = 0;

  function automatic logic [NR*RW-1:0] m_flat();
    logic [NR*RW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*RW +: RW] = m_regs[i];
    return f;
  endfunction

  function automatic logic [7:0] m_word(input logic [AW-1:0] addr);
    return (int'(addr) < NR) ? m_regs[int'(addr)] : 8'h00;
  endfunction

  always @(negedge clk) begin
    bit en, forced, eag, ebg;
    en     = rstb && ena;
    forced = (m_starve >= SL);
    eag    = en && a_if.req && !(forced && b_if.req);
    ebg    = en && b_if.req && (forced || !a_if.req);
    if (a_if.gnt === 1'b1 && b_if.gnt === 1'b1) both_cnt++;
    if (m_valid) begin
      chk("a_gnt", a_if.gnt, eag);
      chk("b_gnt", b_if.gnt, ebg);
      chk("a_rvalid", a_if.rvalid, m_rva && rstb);
      chk("b_rvalid", b_if.rvalid, m_rvb && rstb);
      chk("a_rdata", a_if.rdata, m_rda);
      chk("b_rdata", b_if.rdata, m_rdb);
      chk("config_regs", cfg, m_flat());
      chk("contention_cnt", ccnt, m_cont);
    end
    if (!rstb) begin
      for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
      m_starve = 0; m_cont = 0;
      m_rva = 0; m_rvb = 0; m_rda = 8'h00; m_rdb = 8'h00;
      m_valid = 1'b1;
    end else if (ena) begin
      m_rva = eag && !a_if.we;
      m_rvb = ebg && !b_if.we;
      if (m_rva) m_rda = m_word(a_if.addr);
      if (m_rvb) m_rdb = m_word(b_if.addr);
      if (eag && a_if.we && int'(a_if.addr) < NR) m_regs[int'(a_if.addr)] = a_if.wdata;
      if (ebg && b_if.we && int'(b_if.addr) < NR) m_regs[int'(b_if.addr)] = b_if.wdata;
      if (a_if.req && b_if.req && m_cont < 255) m_cont++;
      if (b_if.req && !ebg) m_starve++;
      else m_starve = 0;
    end else begin
      m_rva = 0; m_rvb = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [7:0] wd);
    a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [7:0] wd);
    b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wd;
  endtask

  initial begin
    logic [NR*RW-1:0] snap;
    int bad;
    rstb = 1'b0;
    ena  = 1'b1;
    set_a(1, 0, 0, 0);
    set_b(1, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_a_gnt", a_if.gnt, 0);
      chk("rst_b_gnt", b_if.gnt, 0);
      chk("rst_rvalid", {a_if.rvalid, b_if.rvalid}, 0);
      chk("rst_cfg", cfg, 0);
      chk("rst_ccnt", ccnt, 0);
      tick();
    end

    rstb = 1'b1;
    set_a(1, 1, 0, 8'hCA);
    set_b(0, 0, 0, 0);
    @(negedge clk); chk("wr_a_gnt", a_if.gnt, 1);
    tick();
    a_if.we = 1'b0;
    @(negedge clk); chk("wr_visible", cfg[7:0], 8'hCA); chk("rd_a_gnt", a_if.gnt, 1);
    tick();
    a_if.req = 1'b0;
    @(negedge clk); chk("rd_a_rvalid", a_if.rvalid, 1); chk("rd_a_rdata", a_if.rdata, 8'hCA);
    tick();

    set_a(1, 0, 1, 0);
    set_b(1, 0, 2, 0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b_if.gnt !== ((i % 5) == 4)) bad++;
      if (i == 100) chk("contention_100", ccnt, 100);
      tick();
    end
    chk("starve_pattern", bad, 0);
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    @(negedge clk); chk("contention_sat", ccnt, 255);
    tick();

    set_a(1, 1, 3, 8'h55);
    set_b(1, 1, 3, 8'hAA);
    @(negedge clk); chk("conf_a_gnt", a_if.gnt, 1); chk("conf_b_gnt", b_if.gnt, 0);
    tick();
    a_if.req = 1'b0;
    @(negedge clk); chk("conf_b_gnt2", b_if.gnt, 1); chk("conf_reg3_a", cfg[31:24], 8'h55);
    tick();
    b_if.req = 1'b0;
    @(negedge clk); chk("conf_reg3_b", cfg[31:24], 8'hAA);
    tick();

    snap = cfg;
    set_b(1, 1, 25, 8'hFF);
    @(negedge clk); chk("oor_b_gnt", b_if.gnt, 1);
    tick();
    b_if.we = 1'b0;
    @(negedge clk); chk("oor_wr_dropped", cfg, snap);
    tick();
    b_if.req = 1'b0;
    @(negedge clk); chk("oor_rvalid", b_if.rvalid, 1); chk("oor_rdata", b_if.rdata, 8'h00);
    tick();

    ena = 1'b0;
    set_a(1, 1, 5, 8'h11);
    set_b(1, 1, 5, 8'h22);
    snap = cfg;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_if.gnt !== 1'b0 || b_if.gnt !== 1'b0) bad++;
      tick();
    end
    @(negedge clk); chk("ena0_no_gnt", bad, 0); chk("ena0_frozen", cfg, snap);
    ena = 1'b1;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    tick();

    set_a(1, 0, 3, 0);
    @(negedge clk); chk("rst_rd_gnt", a_if.gnt, 1);
    tick();
    a_if.req = 1'b0;
    rstb = 1'b0;
    @(negedge clk); chk("rst_rvalid_suppr", a_if.rvalid, 0);
    tick();
    @(negedge clk); chk("rst_cfg_cleared", cfg, 0); chk("rst_ccnt_cleared", ccnt, 0);
    tick();
    rstb = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      ena  = ($urandom % 10) != 0;
      rstb = ($urandom % 100) != 0;
      set_a(($urandom % 3) != 0, $urandom % 2, AW'($urandom_range(0, 31)), 8'($urandom));
      set_b(($urandom % 3) != 0, $urandom % 2, AW'($urandom_range(0, 31)), 8'($urandom));
      tick();
    end
    rstb = 1'b1;
    ena  = 1'b1;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    tick();
    tick();
    chk("mutex_grants", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
